velocity_cell_dbuf: RTL and testbench

Double-buffered per-cell velocity memory. It replaces the single-port velocity cell RAM for the motion-update pipeline. Force evaluation reads velocities from the read bank while motion update writes new {vz, vy, vx} words into the write bank. On a swap request the block commits the write-epoch particle count to address 0 of the write bank and then exchanges the two banks. One instance is used per cell, driven by the velocity cache.

---
 rtl/velocity_cell_dbuf.sv | 143 ++++++++++++++
 tb/tb_velocity_cell_dbuf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_cell_dbuf.sv
// Double-buffered per-cell velocity RAM: force evaluation reads one bank while
// motion update fills the other; a swap commits the particle count then flips banks.
module velocity_cell_dbuf #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] wr_count,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [1:0] {IDLE, COMMIT, SWAP} state_e;

  state_e                  state_q, state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0]   wr_count_q, wr_count_d;
  logic                    addr_err_q, addr_err_d;
  logic                    rd_valid_q;
  logic                    rd_sel_q;
  logic                    rd_zero_q;
  logic [DATA_WIDTH-1:0]   rd_word0_q, rd_word1_q;

  logic [DATA_WIDTH-1:0]   bank0_mem [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0]   bank1_mem [PARTICLE_NUM];

  logic                    commit;
  logic                    rd_acc, wr_acc;
  logic                    rd_in_range, wr_in_range;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign rd_acc      = rd_en && rd_ready;
  assign wr_acc      = wr_en && wr_ready;
  assign rd_in_range = 32'(rd_addr) < 32'(PARTICLE_NUM);
  assign wr_in_range = 32'(wr_addr) < 32'(PARTICLE_NUM);

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_ready  = 1'b0;
    wr_ready  = 1'b0;
    swap_done = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        if (swap_req) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = SWAP;
      end
      SWAP: begin
        swap_done = 1'b1;
        rd_bank_d = ~rd_bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (state_q == SWAP) begin
      wr_count_d = '0;
    end else if (wr_acc && wr_in_range && (wr_addr != '0) && (wr_count_q != LAST_ADDR)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
    addr_err_d = addr_err_q | (rd_acc & ~rd_in_range) | (wr_acc & ~wr_in_range);
  end

  // The commit slot borrows the single write port while normal writes are stalled.
  always_comb begin
    mem_we    = wr_acc && wr_in_range;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (commit) begin
      mem_we    = 1'b1;
      mem_addr  = '0;
      mem_wdata = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, wr_count_q};
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      wr_count_q <= '0;
      addr_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      wr_count_q <= wr_count_d;
      addr_err_q <= addr_err_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_sel_q  <= rd_bank_q;
        rd_zero_q <= ~rd_in_range;
      end
    end
  end

  // NOTE: RAM arrays carry no reset so they map onto block RAM; rst only clears control.
  always_ff @(posedge clk) begin
    if (mem_we && rd_bank_q) bank0_mem[mem_addr] <= mem_wdata;
    if (rd_acc) rd_word0_q <= bank0_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rd_bank_q) bank1_mem[mem_addr] <= mem_wdata;
    if (rd_acc) rd_word1_q <= bank1_mem[rd_addr];
  end

  assign rd_data  = rd_zero_q ? '0 : (rd_sel_q ? rd_word1_q : rd_word0_q);
  assign rd_valid = rd_valid_q;
  assign rd_bank  = rd_bank_q;
  assign wr_count = wr_count_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Scoreboarded bench for velocity_cell_dbuf: reads push expected words, a monitor
// pops them on rd_valid; control outputs are checked directly at fixed cycles.
module tb_velocity_cell_dbuf;

  localparam int DW = 96;
  localparam int AW = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_ready;
  logic          swap_req = 1'b0;
  logic          swap_done;
  logic          rd_bank;
  logic [AW-1:0] wr_count;
  logic          addr_err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  velocity_cell_dbuf dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .swap_req(swap_req), .swap_done(swap_done), .rd_bank(rd_bank),
    .wr_count(wr_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read, in the right cycle.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_data %0h with no read pending (cycle %0d)", rd_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_valid_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = addr;
    e.data  = exp;
    e.cyc   = cyc + 1;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues swap_req in the current cycle T (with whatever write the caller set up),
  // optionally drives ignored traffic during the stall, and checks the 2-cycle window.
  task automatic do_swap(input logic exp_bank, input logic [AW-1:0] exp_commit_cnt,
                         input bit stall_traffic);
    swap_req = 1'b1;
    @(negedge clk);
    check("rd_ready_T", DW'(rd_ready), DW'(1));
    check("wr_ready_T", DW'(wr_ready), DW'(1));
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    if (stall_traffic) begin
      rd_en   = 1'b1;
      rd_addr = 8'd3;
      wr_en   = 1'b1;
      wr_addr = 8'd12;
      wr_data = 96'h5A5A;
    end
    @(negedge clk);
    check("rd_ready_T1", DW'(rd_ready), DW'(0));
    check("wr_ready_T1", DW'(wr_ready), DW'(0));
    check("swap_done_T1", DW'(swap_done), DW'(0));
    check("commit_count", DW'(wr_count), DW'(exp_commit_cnt));
    tick();
    @(negedge clk);
    check("rd_ready_T2", DW'(rd_ready), DW'(0));
    check("wr_ready_T2", DW'(wr_ready), DW'(0));
    check("swap_done_T2", DW'(swap_done), DW'(1));
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("rd_ready_T3", DW'(rd_ready), DW'(1));
    check("wr_ready_T3", DW'(wr_ready), DW'(1));
    check("swap_done_T3", DW'(swap_done), DW'(0));
    check("rd_bank_T3", DW'(rd_bank), DW'(exp_bank));
    check("wr_count_T3", DW'(wr_count), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_rd_bank", DW'(rd_bank), DW'(0));
    check("rst_wr_count", DW'(wr_count), DW'(0));
    check("rst_rd_valid", DW'(rd_valid), DW'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_swap_done", DW'(swap_done), DW'(0));
    check("rst_addr_err", DW'(addr_err), DW'(0));
    check("rst_rd_ready", DW'(rd_ready), DW'(1));
    check("rst_wr_ready", DW'(wr_ready), DW'(1));
    tick();
    rst = 1'b0;
    do_read(8'd5, '0);

    // Fill write bank 1 with addr 1..10, swap, read back count and data
    for (int i = 1; i <= 10; i++) do_write(AW'(i), DW'(i));
    @(negedge clk);
    check("wr_count_10", DW'(wr_count), DW'(10));
    tick();
    do_swap(1'b1, 8'd10, 1'b0);
    tick();
    do_read(8'd0, DW'(10));
    do_read(8'd7, DW'(7));

    // swap_req with a co-issued write; stalled traffic must be ignored
    for (int i = 1; i <= 10; i++) do_write(AW'(i), DW'(100 + i));
    wr_en   = 1'b1;
    wr_addr = 8'd11;
    wr_data = DW'(111);
    do_swap(1'b0, 8'd11, 1'b1);
    tick();
    do_read(8'd0, DW'(11));
    do_read(8'd11, DW'(111));
    do_read(8'd12, '0);
    do_read(8'd4, DW'(104));

    // Saturation: 300 writes cycling 1..219 into bank 1
    for (int i = 0; i < 300; i++) do_write(AW'((i % 219) + 1), DW'(i));
    @(negedge clk);
    check("wr_count_sat", DW'(wr_count), DW'(219));
    tick();
    do_swap(1'b1, 8'd219, 1'b0);
    tick();
    do_read(8'd0, DW'(219));
    do_read(8'd5, DW'(223));
    do_read(8'd219, DW'(218));
    @(negedge clk);
    check("addr_err_inrange", DW'(addr_err), DW'(0));

    // Out-of-range write and read
    tick();
    do_write(8'd230, 96'hDEAD);
    @(negedge clk);
    check("addr_err_wr", DW'(addr_err), DW'(1));
    check("wr_count_drop", DW'(wr_count), DW'(0));
    tick();
    do_read(8'd225, '0);
    do_swap(1'b0, 8'd0, 1'b0);
    tick();
    do_read(8'd0, '0);
    do_read(8'd5, DW'(105));
    @(negedge clk);
    check("addr_err_sticky", DW'(addr_err), DW'(1));

    // Reset during COMMIT: no swap, state cleared, RAM kept
    tick();
    do_write(8'd20, 96'hA0);
    do_write(8'd21, 96'hA1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    @(negedge clk);
    check("in_commit_rd_ready", DW'(rd_ready), DW'(0));
    rst = 1'b1;
    #1;
    check("rstc_rd_bank", DW'(rd_bank), DW'(0));
    check("rstc_wr_count", DW'(wr_count), DW'(0));
    check("rstc_addr_err", DW'(addr_err), DW'(0));
    check("rstc_rd_ready", DW'(rd_ready), DW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("rstc_swap_done", DW'(swap_done), DW'(0));
    end
    tick();
    rst = 1'b0;
    do_swap(1'b1, 8'd0, 1'b0);
    tick();
    do_read(8'd20, 96'hA0);
    do_read(8'd21, 96'hA1);
    do_read(8'd0, '0);
    do_read(8'd7, DW'(225));

    // Out-of-range read alone raises addr_err
    do_read(8'd225, '0);
    tick();
    @(negedge clk);
    check("addr_err_rd", DW'(addr_err), DW'(1));
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
